lsu_bus_bridge: RTL and testbench

- Memory-access stage directly downstream of the core control unit.
- Consumes rmem/wmem/mem_type/mem_sign plus the ALU-computed address and rs2 store data.
- Runs a single-outstanding req/ack transaction on the data bus, with byte-lane steering, load sign/zero extension, misalignment detection and an ack timeout.
- Drives hold back to control so the core state register freezes until the access completes.

---
 rtl/lsu_bus_bridge.sv | 214 +++++++++++++++++++++
 tb/tb_lsu_bus_bridge.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the core control unit and a single-outstanding req/ack data bus.
// Handles byte-lane steering, load extension, misalignment rejection and ack timeout.
module lsu_bus_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rmem,
  input  logic              wmem,
  input  logic [1:0]        mem_type,
  input  logic              mem_sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              hold,
  output logic              misalign,
  output logic              bus_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Last REQ cycle index before the access is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  function automatic logic [3:0] lane_be(input logic [1:0] mt, input logic [1:0] lo);
    case (mt)
      2'b00:   lane_be = 4'b0001 << lo;
      2'b01:   lane_be = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] mt, input logic [31:0] wd);
    case (mt)
      2'b00:   lane_wdata = {4{wd[7:0]}};
      2'b01:   lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] mt, input logic uns,
                                           input logic [1:0] lo, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lo, 3'b000} +: 8];
    h = rd[{lo[1], 4'b0000} +: 16];
    case (mt)
      2'b00:   load_ext = {{24{~uns & b[7]}}, b};
      2'b01:   load_ext = {{16{~uns & h[15]}}, h};
      default: load_ext = rd;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          type_q, type_d;
  logic                sign_q, sign_d;
  logic                we_q, we_d;
  logic [1:0]          lo_q, lo_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                misalign_q, misalign_d;
  logic                fault_q, fault_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]          bus_be_q, bus_be_d;
  logic                req_s;
  logic                aligned_s;

  assign req_s = rmem | wmem;

  always_comb begin
    case (mem_type)
      2'b00:   aligned_s = 1'b1;
      2'b01:   aligned_s = ~addr[0];
      default: aligned_s = (addr[1:0] == 2'b00);
    endcase
  end

  // hold must reach control in the same cycle the request is presented.
  assign hold = ((state_q == S_IDLE) & req_s & aligned_s) | (state_q == S_REQ);

  // Next-state, capture and completion logic.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    sign_d      = sign_q;
    we_d        = we_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    misalign_d  = 1'b0;
    fault_d     = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          if (aligned_s) begin
            state_d     = S_REQ;
            type_d      = mem_type;
            sign_d      = mem_sign;
            we_d        = wmem;
            lo_d        = addr[1:0];
            cnt_d       = 8'd0;
            bus_req_d   = 1'b1;
            bus_we_d    = wmem;
            bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            bus_be_d    = lane_be(mem_type, addr[1:0]);
            bus_wdata_d = wmem ? lane_wdata(mem_type, wdata) : {DATA_W{1'b0}};
          end else begin
            misalign_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_err) begin
          fault_d   = 1'b1;
          rdata_d   = {DATA_W{1'b0}};
          bus_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (bus_ack) begin
          if (!we_q) begin
            rdata_d = load_ext(type_q, sign_q, lo_q, bus_rdata);
          end else begin
            rdata_d = rdata_q;
          end
          bus_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          fault_d   = 1'b1;
          rdata_d   = {DATA_W{1'b0}};
          bus_req_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      type_q      <= 2'b00;
      sign_q      <= 1'b0;
      we_q        <= 1'b0;
      lo_q        <= 2'b00;
      cnt_q       <= 8'd0;
      rdata_q     <= {DATA_W{1'b0}};
      misalign_q  <= 1'b0;
      fault_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= {ADDR_W{1'b0}};
      bus_wdata_q <= {DATA_W{1'b0}};
      bus_be_q    <= 4'b0000;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      sign_q      <= sign_d;
      we_q        <= we_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
      fault_q     <= fault_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
    end
  end

  assign rdata     = rdata_q;
  assign misalign  = misalign_q;
  assign bus_fault = fault_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Bench for lsu_bus_bridge: directed plan cases followed by randomized accesses
// checked against an arithmetic reference model of the bridge.
module tb_lsu_bus_bridge;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rmem, wmem, mem_sign;
  logic [1:0]  mem_type;
  logic [31:0] addr, wdata, rdata;
  logic        hold, misalign, bus_fault, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_err;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] rd_model;

  lsu_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .rmem(rmem), .wmem(wmem), .mem_type(mem_type),
    .mem_sign(mem_sign), .addr(addr), .wdata(wdata), .rdata(rdata), .hold(hold),
    .misalign(misalign), .bus_fault(bus_fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_aligned(input logic [1:0] mt, input logic [31:0] a);
    if (mt == 2'd0) return 1'b1;
    if (mt == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [31:0] ref_be(input logic [1:0] mt, input logic [31:0] a);
    if (mt == 2'd0) return 32'd1 << (a % 4);
    if (mt == 2'd1) return ((a % 4) >= 2) ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] mt, input logic [31:0] wd);
    if (mt == 2'd0) return (wd & 32'd255) * 32'h01010101;
    if (mt == 2'd1) return (wd & 32'd65535) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] mt, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (mt == 2'd0) begin
      v = (rd >> (8 * (a % 4))) & 32'd255;
      if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (mt == 2'd1) begin
      v = (rd >> (((a % 4) >= 2) ? 16 : 0)) & 32'd65535;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // k = cycle of REQ in which the bus responds (0 = never, forcing a timeout).
  task automatic access(input logic wr, input logic both, input logic [1:0] mt,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input int k, input logic err, input logic [31:0] brd);
    logic        al;
    int          ncyc;
    logic        fault_exp;
    al = ref_aligned(mt, a);
    @(posedge clk); #1;
    rmem = ~wr | both; wmem = wr; mem_type = mt; mem_sign = sg; addr = a; wdata = wd;
    @(negedge clk);
    chk("hold_on_request", {31'd0, hold}, {31'd0, al});
    if (!al) begin
      @(posedge clk); #1;
      rmem = 1'b0; wmem = 1'b0;
      @(negedge clk);
      chk("misalign_pulse", {31'd0, misalign}, 32'd1);
      chk("misalign_no_req", {31'd0, bus_req}, 32'd0);
      chk("misalign_hold", {31'd0, hold}, 32'd0);
      chk("misalign_rdata", rdata, rd_model);
      @(posedge clk); #1;
      @(negedge clk);
      chk("misalign_once", {31'd0, misalign}, 32'd0);
      return;
    end
    ncyc = (k == 0) ? TO : k;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      addr = $urandom; wdata = $urandom; mem_type = 2'($urandom);
      if (c == k) begin
        bus_ack   = ~err | 1'($urandom);
        bus_err   = err;
        bus_rdata = brd;
      end
      if (c == ncyc) begin
        rmem = 1'b0; wmem = 1'b0;
      end
      @(negedge clk);
      chk("req_high", {31'd0, bus_req}, 32'd1);
      chk("req_hold", {31'd0, hold}, 32'd1);
      chk("req_addr", bus_addr, a & 32'hFFFFFFFC);
      chk("req_be", {28'd0, bus_be}, ref_be(mt, a));
      chk("req_wdata", bus_wdata, wr ? ref_wdata(mt, wd) : 32'd0);
      chk("req_we", {31'd0, bus_we}, {31'd0, wr});
    end
    if (k != 0 && !err) begin
      fault_exp = 1'b0;
      if (!wr) rd_model = ref_load(mt, sg, a, brd);
    end else begin
      fault_exp = 1'b1;
      rd_model  = 32'd0;
    end
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    chk("done_hold", {31'd0, hold}, 32'd0);
    chk("done_req_low", {31'd0, bus_req}, 32'd0);
    chk("done_fault", {31'd0, bus_fault}, {31'd0, fault_exp});
    chk("done_rdata", rdata, rd_model);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_fault_low", {31'd0, bus_fault}, 32'd0);
    chk("idle_rdata", rdata, rd_model);
  endtask

  initial begin
    rstn = 1'b0; rmem = 1'b0; wmem = 1'b0; mem_type = 2'd0; mem_sign = 1'b0;
    addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
    rd_model = 32'd0;
    #12;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_flags", {29'd0, misalign, bus_fault, hold}, 32'd0);
    @(negedge clk); rstn = 1'b1;

    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 3, 1'b0, 32'hDEADBEEF);
    chk("word_load", rd_model, 32'hDEADBEEF);
    access(1'b0, 1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 1, 1'b0, 32'h80112233);
    chk("byte_signed", rdata, 32'hFFFFFF80);
    access(1'b0, 1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 2, 1'b0, 32'h80112233);
    chk("byte_unsigned", rdata, 32'h00000080);
    access(1'b1, 1'b0, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 1, 1'b0, 32'd0);
    chk("half_store_keeps_rdata", rdata, 32'h00000080);
    access(1'b1, 1'b1, 2'd1, 1'b0, 32'h206, 32'h1234ABCD, 2, 1'b0, 32'h55555555);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h301, 32'h11111111, 1, 1'b0, 32'd0);
    access(1'b0, 1'b0, 2'd1, 1'b0, 32'h402, 32'd0, 1, 1'b0, 32'h8001FFFF);
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h500, 32'd0, 0, 1'b0, 32'd0);
    chk("timeout_rdata", rdata, 32'd0);
    access(1'b0, 1'b0, 2'd3, 1'b0, 32'h600, 32'd0, TO, 1'b0, 32'hCAFEF00D);
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h700, 32'd0, 2, 1'b1, 32'h12345678);

    // Reset while the bus request is outstanding.
    @(posedge clk); #1;
    rmem = 1'b1; wmem = 1'b0; mem_type = 2'd2; addr = 32'h800;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_reset_req", {31'd0, bus_req}, 32'd1);
    rmem = 1'b0; rstn = 1'b0;
    #1;
    chk("reset_req_drop", {31'd0, bus_req}, 32'd0);
    chk("reset_hold", {31'd0, hold}, 32'd0);
    rd_model = 32'd0;
    @(posedge clk); #1; rstn = 1'b1;
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h900, 32'd0, 1, 1'b0, 32'hA5A5A5A5);

    for (int i = 0; i < 60; i++) begin
      access(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
             {24'h0, 8'($urandom)}, $urandom, $urandom_range(0, TO),
             ($urandom % 5) == 0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
